counter_event_capture: RTL and testbench
========================================

# counter_event_capture

Downstream consumer of the counter host's status outputs. Samples `count_in`, `pulse_in` and `overflow_in` every cycle and turns each pulse or overflow event into a tagged record. Records are timestamped with the current count and buffered in a small synchronous FIFO. They are drained through a valid/ready stream, and events lost to back-pressure are counted so software can detect gaps.

## Interface
Parameters:
- `COUNT_WIDTH`, default 12: width of `count_in`; must match the counter host.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `DROP_WIDTH`, default 8: width of the saturating drop counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `capture_en`  in  1: when low, events are ignored (not recorded, not dropped, no sequence advance).
- `clear`  in  1: synchronous flush of FIFO, drop counter and sequence number.
- `count_in`  in  COUNT_WIDTH: counter value from the host.
- `pulse_in`  in  1: periodic pulse from the host.
- `overflow_in`  in  1: overflow flag from the host.
- `evt_valid`  out  1: head record available.
- `evt_ready`  in  1: consumer accepts the head record.
- `evt_data`  out  COUNT_WIDTH+4: record, laid out as {tag[1:0], seq[1:0], count[COUNT_WIDTH-1:0]}.
- `fifo_level`  out  $clog2(DEPTH)+1: current occupancy.
- `drop_count`  out  DROP_WIDTH: events lost to a full FIFO; saturates at all-ones.

## Operation
- **Event detection:** an event occurs in any cycle with `capture_en`=1 and (`pulse_in` | `overflow_in`).
- **Tag encoding:**
  - 2'b01: pulse only.
  - 2'b10: overflow only.
  - 2'b11: both in the same cycle, giving one record.
  - 2'b00 is never emitted.
- **Record contents:** {tag, seq, `count_in` sampled that cycle}.
- **Sequence number:** `seq` is a 2-bit counter that increments on every event, whether accepted or dropped and regardless of FIFO state. It wraps 3→0. Gaps in `seq` at the consumer reveal drops.
- **Push rule:** a push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle (`evt_valid` & `evt_ready`).
- **Drop rule:** otherwise the event is dropped and `drop_count` increments, saturating at 2^DROP_WIDTH−1.
- **Pop:** occurs on `evt_valid` & `evt_ready`. `evt_data` shows the FIFO head (show-ahead) and holds stable while `evt_valid`=1 and `evt_ready`=0.
- **Clear:** `clear`=1 empties the FIFO and zeroes `drop_count` and `seq`. Any event in that same cycle is discarded, and clear takes priority over push and pop.
- **Reset values:** `evt_valid`=0, `evt_data`=0, `fifo_level`=0, `drop_count`=0, `seq`=0. Reset mid-stream discards all buffered records.
- **No FSM beyond FIFO state:** the FIFO uses read and write pointers with one extra wrap bit. `full` means the pointers differ only in the MSB; `empty` means they are equal.

## Timing
- Event sampled at rising edge N, then written to the FIFO at edge N.
- If the FIFO was empty, `evt_valid` is high in the cycle after edge N, so latency is 1 cycle. There is no same-cycle bypass.
- A pop at edge M presents the next record, or drops `evt_valid`, in the cycle after M.
- `fifo_level` and `drop_count` are registered and reflect edge-N activity in the cycle after N.
- With a simultaneous push and pop, `fifo_level` is unchanged.
- Back-to-back events every cycle with `evt_ready` held at 1 sustain a throughput of one record per cycle with no drops.

## Structure
- **Shared package:** holds the tag constants (TAG_PULSE=2'b01, TAG_OVF=2'b10, TAG_BOTH=2'b11) and the record field offsets, so the host-side decoder and the bench use the same definitions.
- **Sub-module:** one, `event_fifo`, a parameterized synchronous show-ahead FIFO with `push`, `pop`, `clear`, `full`, `empty` and `level`.
- **Top level:** event detection, tag and sequence generation, and the drop counter live in the top module.

## Test plan
- Single pulse at `count_in`=0x063, FIFO empty, `evt_ready`=0 → next cycle `evt_valid`=1 and `evt_data`=0x4063 (tag 01, seq 0); the value holds until `evt_ready` rises.
- `pulse_in` and `overflow_in` high together with `count_in`=0xFFF → one record with tag 11 and `evt_data`=0xCFFF; `fifo_level` increments by exactly 1.
- `evt_ready`=0 with 10 events → `fifo_level`=8 and `drop_count`=2. Drained `seq` values are 0,1,2,3,0,1,2,3, and the next accepted event has seq 2.
- FIFO full, event coincident with a pop → event accepted, `fifo_level` stays 8, `drop_count` unchanged.
- 300 events with `evt_ready`=0 and DROP_WIDTH=8 → `drop_count` saturates at 0xFF. Asserting `clear` then gives `fifo_level`=0, `drop_count`=0, `evt_valid`=0 next cycle, and the next event carries seq 0.
- `rst` asserted asynchronously with 5 records buffered → all outputs are 0 immediately; after release, the first event yields seq 0 with 1-cycle latency.

Source files
------------

// File: rtl/counter_event_capture_pkg.sv
// Shared definitions for counter event records: tag codes, field widths and
// field offsets. Record layout is {tag, seq, count}, with count at bit 0.
// The seq and tag offsets are measured from the top of the count field.
package counter_event_capture_pkg;

    localparam int unsigned TAG_W = 2;
    localparam int unsigned SEQ_W = 2;
    localparam int unsigned HDR_W = TAG_W + SEQ_W;

    // Offsets of the header fields above the count field.
    localparam int unsigned SEQ_OFS = 0;
    localparam int unsigned TAG_OFS = SEQ_W;

    localparam logic [TAG_W-1:0] TAG_PULSE = 2'b01;
    localparam logic [TAG_W-1:0] TAG_OVF   = 2'b10;
    localparam logic [TAG_W-1:0] TAG_BOTH  = 2'b11;

    // Tag for a cycle's event inputs. Returns 2'b00 only when there is no
    // event, and such a tag is never written into a record.
    function automatic logic [TAG_W-1:0] event_tag(input logic pulse, input logic ovf);
        if (pulse && ovf) begin
            return TAG_BOTH;
        end else if (ovf) begin
            return TAG_OVF;
        end else if (pulse) begin
            return TAG_PULSE;
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst   : clock, async active-high reset
//   clear      : synchronous flush; takes priority over push and pop
//   push/wdata : write request and data; accepted when not full, or when full
//                with a pop in the same cycle
//   pop        : remove the head entry; ignored when empty
//   rdata      : head entry, or zero when the FIFO is empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
module event_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head is forced to zero when empty so stale entries never leak out.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage; when full with a coincident pop, the write lands in the slot
    // being vacated, which is safe because the head is read before the edge.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/counter_event_capture.sv
// Captures pulse/overflow events from the counter host as tagged, sequenced,
// timestamped records, buffers them in a show-ahead FIFO and drains them
// through a valid/ready stream. Events lost to a full FIFO are counted.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   capture_en                   : gate for event detection
//   clear                        : synchronous flush of FIFO, drop count, seq
//   count_in, pulse_in, overflow_in : host status sampled every cycle
//   evt_valid, evt_ready, evt_data : record stream {tag, seq, count}
//   fifo_level                   : FIFO occupancy
//   drop_count                   : saturating count of dropped events
module counter_event_capture
    import counter_event_capture_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 12,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DROP_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         capture_en,
    input  logic                         clear,
    input  logic [COUNT_WIDTH-1:0]       count_in,
    input  logic                         pulse_in,
    input  logic                         overflow_in,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [COUNT_WIDTH+3:0]       evt_data,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [DROP_WIDTH-1:0]        drop_count
);

    localparam int unsigned REC_W = COUNT_WIDTH + HDR_W;

    logic              evt;
    logic              pop_fire;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_WIDTH-1:0] drop_q;
    logic [REC_W-1:0]  rec;

    assign evt       = capture_en & (pulse_in | overflow_in);
    assign evt_valid = ~fifo_empty;
    assign pop_fire  = evt_valid & evt_ready;
    // A full FIFO still takes the event if the head leaves in the same cycle.
    assign drop      = evt & fifo_full & ~pop_fire;
    assign drop_count = drop_q;

    // Record assembly from the current cycle's inputs and sequence number.
    always_comb begin
        rec = '0;
        rec[COUNT_WIDTH-1:0]                = count_in;
        rec[COUNT_WIDTH+SEQ_OFS +: SEQ_W]   = seq_q;
        rec[COUNT_WIDTH+TAG_OFS +: TAG_W]   = event_tag(pulse_in, overflow_in);
    end

    // Sequence advances on every event, accepted or dropped; drop count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q  <= '0;
            drop_q <= '0;
        end else if (clear) begin
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            if (evt) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_WIDTH'(1);
            end
        end
    end

    event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (evt),
        .wdata (rec),
        .pop   (pop_fire),
        .rdata (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_counter_event_capture.sv
// Bench for counter_event_capture: directed scenarios plus random traffic.
// A stimulus task updates a behavioural model and queues expected records
// and expected level/drop snapshots; two monitor processes compare them.
module tb_counter_event_capture;
    import counter_event_capture_pkg::*;

    localparam int CW    = 12;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int RW    = CW + 4;
    localparam int DMAX  = (1 << DW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           capture_en;
    logic           clear;
    logic [CW-1:0]  count_in;
    logic           pulse_in;
    logic           overflow_in;
    logic           evt_valid;
    logic           evt_ready;
    logic [RW-1:0]  evt_data;
    logic [3:0]     fifo_level;
    logic [DW-1:0]  drop_count;

    always #5 clk = ~clk;

    counter_event_capture #(
        .COUNT_WIDTH (CW),
        .DEPTH       (DEPTH),
        .DROP_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .clear       (clear),
        .count_in    (count_in),
        .pulse_in    (pulse_in),
        .overflow_in (overflow_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    typedef struct {
        int level;
        int drops;
    } chk_t;

    int            total = 0;
    int            bad   = 0;
    logic [RW-1:0] exp_q[$];
    chk_t          chk_q[$];
    int            m_level = 0;
    int            m_drops = 0;
    int            m_seq   = 0;
    bit            mon_en  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_tag(input bit p, input bit o);
        if (p && o) return TAG_BOTH;
        if (p)      return TAG_PULSE;
        return TAG_OVF;
    endfunction

    // One clock of stimulus; the model decides what the edge should do.
    task automatic step(input bit cap, input bit clr, input logic [CW-1:0] cnt,
                        input bit p, input bit o, input bit rdy);
        logic [RW-1:0] rec;
        @(negedge clk);
        #1;
        capture_en  = cap;
        clear       = clr;
        count_in    = cnt;
        pulse_in    = p;
        overflow_in = o;
        evt_ready   = rdy;
        if (clr) begin
            exp_q.delete();
            m_level = 0;
            m_drops = 0;
            m_seq   = 0;
        end else begin
            if (rdy && m_level > 0) m_level--;
            if (cap && (p || o)) begin
                rec   = {model_tag(p, o), 2'(m_seq), cnt};
                m_seq = (m_seq + 1) % 4;
                if (m_level < DEPTH) begin
                    m_level++;
                    exp_q.push_back(rec);
                end else if (m_drops < DMAX) begin
                    m_drops++;
                end
            end
        end
        chk_q.push_back('{m_level, m_drops});
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, CW'($urandom), 1'b0, 1'b0, rdy);
    endtask

    task automatic events(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, CW'($urandom), 1'b1, 1'b0, rdy);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Head-of-stream monitor: compares the presented record, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst && !clear && evt_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_record: evt_data=0x%0h, none expected", evt_data);
                end else begin
                    check("head_data", longint'(evt_data), longint'(exp_q[0]));
                    if (evt_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Status monitor: level, drop count and valid after each edge.
    initial begin
        chk_t c;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check("fifo_level", longint'(fifo_level), longint'(c.level));
                check("drop_count", longint'(drop_count), longint'(c.drops));
                check("evt_valid", longint'(evt_valid), longint'(c.level != 0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; capture_en = 1'b0; count_in = '0;
        pulse_in = 1'b0; overflow_in = 1'b0; evt_ready = 1'b0;
        #12;
        check("reset_valid", longint'(evt_valid), 0);
        check("reset_data", longint'(evt_data), 0);
        check("reset_level", longint'(fifo_level), 0);
        check("reset_drops", longint'(drop_count), 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single pulse, held with ready low, then drained.
        step(1'b1, 1'b0, 12'h063, 1'b1, 1'b0, 1'b0);
        settle();
        check("pulse_valid", longint'(evt_valid), 1);
        check("pulse_data", longint'(evt_data), 64'h4063);
        idle(3, 1'b0);
        settle();
        check("pulse_hold", longint'(evt_data), 64'h4063);
        idle(2, 1'b1);

        // Pulse and overflow together give one record tagged 11.
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b0);
        settle();
        check("both_data", longint'(evt_data), 64'hCFFF);
        check("both_level", longint'(fifo_level), 1);
        idle(2, 1'b1);

        // Ten events into eight slots, drain, then the next seq must be 2.
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        events(10, 1'b0);
        settle();
        check("over_level", longint'(fifo_level), 8);
        check("over_drops", longint'(drop_count), 2);
        idle(8, 1'b1);
        step(1'b1, 1'b0, 12'h5A5, 1'b0, 1'b1, 1'b0);
        settle();
        check("seq_after_drops", longint'(evt_data[CW+1:CW]), 2);
        idle(2, 1'b1);

        // Full FIFO with an event coincident with a pop.
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        events(8, 1'b0);
        events(1, 1'b1);
        settle();
        check("full_pop_level", longint'(fifo_level), 8);
        check("full_pop_drops", longint'(drop_count), 0);
        idle(10, 1'b1);

        // Back-to-back events with ready held high.
        events(20, 1'b1);
        idle(2, 1'b1);

        // Drop counter saturation, then clear (with a discarded event).
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        events(300, 1'b0);
        settle();
        check("sat_drops", longint'(drop_count), 255);
        step(1'b1, 1'b1, 12'h111, 1'b1, 1'b0, 1'b0);
        settle();
        check("clear_level", longint'(fifo_level), 0);
        check("clear_drops", longint'(drop_count), 0);
        check("clear_valid", longint'(evt_valid), 0);
        step(1'b1, 1'b0, 12'h222, 1'b1, 1'b0, 1'b0);
        settle();
        check("seq_after_clear", longint'(evt_data[CW+1:CW]), 0);
        idle(2, 1'b1);

        // Asynchronous reset with five records buffered.
        events(5, 1'b0);
        settle();
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        capture_en = 1'b0; pulse_in = 1'b0; overflow_in = 1'b0; evt_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", longint'(evt_valid), 0);
        check("arst_data", longint'(evt_data), 0);
        check("arst_level", longint'(fifo_level), 0);
        check("arst_drops", longint'(drop_count), 0);
        exp_q.delete();
        chk_q.delete();
        m_level = 0; m_drops = 0; m_seq = 0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0);
        settle();
        check("post_rst_valid", longint'(evt_valid), 1);
        check("post_rst_data", longint'(evt_data), 64'h4123);
        idle(2, 1'b1);

        // Random traffic in phases of differing back-pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 700; i++) begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 149) == 0,
                     CW'($urandom),
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) < ph + 1);
            end
        end
        idle(12, 1'b1);
        settle();
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
